// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/busy/done handshake and registered results.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] difference,
  output logic         borrow_out,
  output logic         zero
);

  localparam int CW = (N + 1 > 2) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          borrow_q, borrow_d;
  logic          bout_q, bout_d;
  logic          zero_q, zero_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          bit_a, bit_b, bit_d, bit_borrow;
  logic [N:0]    r_cat;

  always_comb begin
    bit_a      = a_q[0];
    bit_b      = b_q[0];
    bit_d      = bit_a ^ bit_b ^ borrow_q;
    bit_borrow = (~bit_a & bit_b) | (~bit_a & borrow_q) | (bit_b & borrow_q);
    // New result bit enters at the MSB; taking [N:1] also works for N=1.
    r_cat      = {bit_d, r_q};

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = minuend;
          b_d      = subtrahend;
          r_d      = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        r_d      = r_cat[N:1];
        borrow_d = bit_borrow;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = r_cat[N:1];
          bout_d  = bit_borrow;
          zero_d  = (r_cat[N:1] == '0);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign difference = diff_q;
  assign borrow_out = bout_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4): directed scenarios plus a
// shuffled sweep of all operand pairs against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] minuend;
  logic [N-1:0] subtrahend;
  logic         busy;
  logic         done;
  logic [N-1:0] difference;
  logic         borrow_out;
  logic         zero;

  int checks;
  int failures;

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic, no bit-level detail.
  function automatic logic [N-1:0] ref_diff(input int a, input int b);
    int r;
    r = (a - b) % (1 << N);
    if (r < 0) r += (1 << N);
    return r[N-1:0];
  endfunction

  // Drives one start pulse from IDLE and watches until done, then one more
  // cycle so the DUT is back in IDLE. Checking is left to the caller.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int done_at, output int busy_cycles,
                        output int done_pulses, output logic [N-1:0] held_diff);
    done_at     = -1;
    busy_cycles = 0;
    done_pulses = 0;
    held_diff   = 'x;
    @(negedge clk);
    minuend    = a;
    subtrahend = b;
    start      = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start      = 1'b0;
        minuend    = N'($urandom);
        subtrahend = N'($urandom);
        held_diff  = difference;
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_at < 0) done_at = k;
      end
      if (done_at > 0 && k == done_at + 1) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    minuend = '0;
    subtrahend = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, difference, borrow_out, zero} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b zero=%b, expected all 0",
               busy, done, difference, borrow_out, zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int a_tab [4] = '{9, 3, 5, 0};
    int b_tab [4] = '{3, 9, 5, 15};
    int done_at, busy_cycles, pulses;
    logic [N-1:0] held;
    for (int i = 0; i < 4; i++) begin
      run_op(N'(a_tab[i]), N'(b_tab[i]), done_at, busy_cycles, pulses, held);
      checks++;
      if (done_at != N + 1) begin
        failures++;
        $display("[TB] FAIL latency %0d-%0d: done at cycle %0d, expected %0d", a_tab[i], b_tab[i], done_at, N + 1);
      end
      checks++;
      if (busy_cycles != N) begin
        failures++;
        $display("[TB] FAIL busy_len %0d-%0d: busy %0d cycles, expected %0d", a_tab[i], b_tab[i], busy_cycles, N);
      end
      checks++;
      if (difference !== ref_diff(a_tab[i], b_tab[i])) begin
        failures++;
        $display("[TB] FAIL diff %0d-%0d: got %h, expected %h", a_tab[i], b_tab[i], difference, ref_diff(a_tab[i], b_tab[i]));
      end
      checks++;
      if (borrow_out !== (a_tab[i] < b_tab[i])) begin
        failures++;
        $display("[TB] FAIL borrow %0d-%0d: got %b, expected %b", a_tab[i], b_tab[i], borrow_out, a_tab[i] < b_tab[i]);
      end
      checks++;
      if (zero !== (a_tab[i] == b_tab[i])) begin
        failures++;
        $display("[TB] FAIL zero %0d-%0d: got %b, expected %b", a_tab[i], b_tab[i], zero, a_tab[i] == b_tab[i]);
      end
    end
    // Results must hold while idle.
    repeat (3) @(negedge clk);
    checks++;
    if (difference !== 4'h1 || borrow_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_hold: got diff=%h bout=%b, expected diff=1 bout=1", difference, borrow_out);
    end
  endtask

  task automatic test_ignore_start;
    int pulses;
    int done_at;
    pulses  = 0;
    done_at = -1;
    @(negedge clk);
    minuend    = 4'd15;
    subtrahend = 4'd0;
    start      = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      // Retry a start mid-SHIFT and again while done is high.
      if (k == 2 || done) begin
        minuend    = 4'd1;
        subtrahend = 4'd1;
        start      = 1'b1;
      end
      if (done_at > 0 && k > done_at + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL ignore_queued: busy=%b at cycle %0d, expected 0", busy, k);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("[TB] FAIL ignore_pulses: got %0d done pulses, expected 1", pulses);
    end
    checks++;
    if (difference !== 4'd15 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_result: got diff=%h zero=%b, expected diff=f zero=0", difference, zero);
    end
  endtask

  task automatic test_reset_abort;
    int done_at, busy_cycles, pulses;
    logic [N-1:0] held;
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    minuend    = 4'd12;
    subtrahend = 4'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, difference, borrow_out, zero} !== '0) begin
      failures++;
      $display("[TB] FAIL abort_async: got busy=%b done=%b diff=%h bout=%b zero=%b, expected all 0",
               busy, done, difference, borrow_out, zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_no_done: done seen after abort, expected none");
    end
    run_op(4'd12, 4'd7, done_at, busy_cycles, pulses, held);
    checks++;
    if (done_at != N + 1 || difference !== 4'd5 || borrow_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_rerun: done_at=%0d diff=%h bout=%b, expected done_at=%0d diff=5 bout=0",
               done_at, difference, borrow_out, N + 1);
    end
  endtask

  task automatic test_back_to_back;
    int order [256];
    int done_at, busy_cycles, pulses;
    logic [N-1:0] held, prev;
    int a, b, j, t;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    prev = difference;
    for (int i = 0; i < 256; i++) begin
      a = order[i] / 16;
      b = order[i] % 16;
      run_op(N'(a), N'(b), done_at, busy_cycles, pulses, held);
      checks++;
      if (done_at != N + 1 || pulses != 1) begin
        failures++;
        $display("[TB] FAIL sweep_handshake %0d-%0d: done_at=%0d pulses=%0d, expected %0d and 1", a, b, done_at, pulses, N + 1);
      end
      checks++;
      if (held !== prev) begin
        failures++;
        $display("[TB] FAIL sweep_hold %0d-%0d: diff during op %h, expected previous %h", a, b, held, prev);
      end
      checks++;
      if (difference !== ref_diff(a, b) || borrow_out !== (a < b) || zero !== (a == b)) begin
        failures++;
        $display("[TB] FAIL sweep_result %0d-%0d: got diff=%h bout=%b zero=%b, expected diff=%h bout=%b zero=%b",
                 a, b, difference, borrow_out, zero, ref_diff(a, b), a < b, a == b);
      end
      prev = ref_diff(a, b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
